// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO feeding an 8-bit UART transmitter.
//
// Bytes strobed in on datavalid are queued in a FIFO_DEPTH-entry FIFO and sent
// LSB first as start / 8 data / [parity] / stop frames, each bit held for
// CLKS_PER_BIT clocks. Frames queued behind one another are sent back to back.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after
// the data bits (11-bit frame); otherwise frames are 8N1 (10 bits).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   data       byte to queue
//   datavalid  single-cycle strobe qualifying data
//   tx         registered serial output, idle high
//   busy       frame in flight or FIFO non-empty
//   full       FIFO holds FIFO_DEPTH bytes
//   overflow   sticky: a byte was dropped because the FIFO was full
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       datavalid,
   output logic       tx,
   output logic       busy,
   output logic       full,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [BW-1:0]   baud;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;

   logic            nonempty;
   logic            baud_end;
   logic            push;
   logic            pop;
   logic [7:0]      head;

   assign nonempty = (count != '0);
   assign baud_end = (baud == BAUD_LAST);
   assign head     = mem[rd_ptr];
   // full is taken from the pre-edge count, so a same-edge pop never admits a write.
   assign push     = datavalid && !full;
   // The FIFO head is consumed either from IDLE or at the last cycle of STOP,
   // which is what gives gap-free back-to-back frames.
   assign pop      = nonempty && ((state == IDLE) || ((state == STOP) && baud_end));

   assign full     = (count == DEPTH_C);
   assign busy     = (state != IDLE) || nonempty;

   // ---------------- FIFO storage (no reset needed; count defines validity)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

   // ---------------- FIFO pointers, count, overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (datavalid && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // ---------------- Transmit FSM with registered tx
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud <= '0;
               if (nonempty) begin
                  state <= START;
                  tx    <= 1'b0;
                  shreg <= head;
               end
            end

            START: begin
               if (baud_end) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            DATA: begin
               if (baud_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= ^shreg;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  baud  <= '0;
                  tx    <= 1'b1;
                  state <= STOP;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`endif

            STOP: begin
               if (baud_end) begin
                  baud <= '0;
                  if (nonempty) begin
                     tx    <= 1'b0;
                     shreg <= head;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               baud  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); legal values >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte FIFO entries; legal values are powers of two >= 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data, input, 8 bits: byte from the upstream byte source.
REQ-006 SHALL have port datavalid, input, 1 bit: single-cycle strobe qualifying data.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is shifting or the FIFO is non-empty.
REQ-009 SHALL have port full, output, 1 bit: FIFO count == FIFO_DEPTH.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set by a dropped byte.

Function
REQ-011 SHALL write data into the FIFO on a clk edge where datavalid=1 and full=0.
REQ-012 SHALL drop the byte and set overflow when datavalid=1 and full=1; full is evaluated on the pre-edge count, so a same-cycle pop does not admit the write.
REQ-013 SHALL advance FIFO pointers modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits wide; a simultaneous push and pop leaves the count unchanged.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (macro-dependent), and STOP.
REQ-015 SHALL move IDLE->START on the first edge with the FIFO non-empty, popping the head into the shift register on that edge.
REQ-016 SHALL drive tx=0 registered at entry to START; a datavalid captured at edge N into an empty FIFO while IDLE gives tx low from edge N+1.
REQ-017 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a baud counter reloaded at each bit boundary.
REQ-018 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit index, then go to PARITY or STOP.
REQ-019 SHALL drive tx=1 for one bit period in STOP, then pop and go directly to START if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-020 SHALL register tx; there are no combinational paths from inputs to outputs.
REQ-021 SHALL ignore datavalid with respect to an in-flight frame; an in-flight frame is never altered by writes.

Reset
REQ-022 SHALL, while rst=1, immediately force tx=1, busy=0, full=0, overflow=0, FSM=IDLE, FIFO empty, and counters=0.
REQ-023 SHALL abort any frame in progress when reset is asserted mid-frame, discarding all queued bytes; after release, the line stays idle until a new write.
REQ-024 SHALL clear overflow only by reset.

Configuration
REQ-025 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA sending even parity (XOR of the 8 data bits) for one bit period, for an 11-bit frame.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state entirely, for a 10-bit frame (8N1).

Verification
REQ-027 SHALL cover single byte with CLKS_PER_BIT=4, no parity: strobe 0x40 while idle -> tx bits 0,0,0,0,0,0,0,1,0,1, each 4 cycles wide (40 cycles), busy=1 throughout, then busy=0.
REQ-028 SHALL cover back-to-back writes: strobe 0x41..0x46 on 6 consecutive cycles from idle, depth 4 -> full asserted after the 5th write, 0x46 dropped, overflow=1, and 0x41..0x45 sent with no idle bits between stop and start.
REQ-029 SHALL cover parity with UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1, 0x03 -> parity bit 0, and each frame is 11 bit periods long.
REQ-030 SHALL cover reset mid-frame: assert rst during the DATA bit 3 of 0x55 with 2 bytes queued -> tx=1 within the same cycle, busy=0, and no further frames after release.
REQ-031 SHALL cover pointer wrap: send 10 bytes spaced so the FIFO never fills -> all 10 received in order, overflow stays 0, and full never asserts.
